// File: rtl/dpram_wr_ctrl.sv
// Ping-pong byte writer for the 64x8 RAM; two 32-byte halves (wa[5]).
// Ports: byte stream in, RAM write strobe/addr/data out, per-half rdy/len, rel.
// Optional DPWR_DROP_CNT_EN: no backpressure; drops counted in drop_cnt.
module dpram_wr_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  input  logic       flush,
  output logic       we,
  output logic [5:0] wa,
  output logic [7:0] wd,
  output logic [1:0] rdy,
  output logic [5:0] len0,
  output logic [5:0] len1,
  input  logic [1:0] rel
`ifdef DPWR_DROP_CNT_EN
  ,
  output logic [7:0] drop_cnt
`endif
);

  logic       we_q, we_d;
  logic [5:0] wa_q, wa_d;
  logic [7:0] wd_q, wd_d;
  logic [1:0] rdy_q, rdy_d;
  logic [5:0] len0_q, len0_d;
  logic [5:0] len1_q, len1_d;
  logic       half_q, half_d;
  logic [4:0] ptr_q, ptr_d;

  logic       full;
  logic       acc;
  logic       close;
  logic [5:0] clen;

  assign full = rdy_q[half_q];

`ifdef DPWR_DROP_CNT_EN
  logic [7:0] drop_q, drop_d;
  logic       drop;

  assign in_ready = 1'b1;
  assign acc      = in_valid && !full;
  assign drop     = in_valid && full;
  assign drop_cnt = drop_q;

  always_comb begin
    drop_d = drop_q;
    if (drop && drop_q != 8'hff)
      drop_d = drop_q + 8'd1;
  end
`else
  assign in_ready = !full;
  assign acc      = in_valid && in_ready;
`endif

  // A flush that coincides with byte 31 is the same single close.
  assign close = (acc && ptr_q == 5'd31) ||
                 (flush && (ptr_q != 5'd0 || acc));
  assign clen  = {1'b0, ptr_q} + {5'd0, acc};

  always_comb begin
    we_d   = acc;
    wa_d   = wa_q;
    wd_d   = wd_q;
    ptr_d  = ptr_q;
    half_d = half_q;
    len0_d = len0_q;
    len1_d = len1_q;
    // Release first so a same-cycle close of that half wins.
    rdy_d  = rdy_q & ~rel;
    if (acc) begin
      wa_d  = {half_q, ptr_q};
      wd_d  = in_data;
      ptr_d = ptr_q + 5'd1;
    end
    if (close) begin
      rdy_d[half_q] = 1'b1;
      if (half_q) len1_d = clen;
      else        len0_d = clen;
      half_d = ~half_q;
      ptr_d  = 5'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q   <= 1'b0;
      wa_q   <= 6'd0;
      wd_q   <= 8'd0;
      rdy_q  <= 2'b00;
      len0_q <= 6'd0;
      len1_q <= 6'd0;
      half_q <= 1'b0;
      ptr_q  <= 5'd0;
`ifdef DPWR_DROP_CNT_EN
      drop_q <= 8'd0;
`endif
    end else begin
      we_q   <= we_d;
      wa_q   <= wa_d;
      wd_q   <= wd_d;
      rdy_q  <= rdy_d;
      len0_q <= len0_d;
      len1_q <= len1_d;
      half_q <= half_d;
      ptr_q  <= ptr_d;
`ifdef DPWR_DROP_CNT_EN
      drop_q <= drop_d;
`endif
    end
  end

  assign we   = we_q;
  assign wa   = wa_q;
  assign wd   = wd_q;
  assign rdy  = rdy_q;
  assign len0 = len0_q;
  assign len1 = len1_q;

endmodule

// File: tb/tb_dpram_wr_ctrl.sv
// Directed self-checking bench for dpram_wr_ctrl.
// Inputs change just after posedge; outputs are checked 1ns after posedge.
module tb_dpram_wr_ctrl;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       flush;
  logic       we;
  logic [5:0] wa;
  logic [7:0] wd;
  logic [1:0] rdy;
  logic [5:0] len0;
  logic [5:0] len1;
  logic [1:0] rel;
`ifdef DPWR_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  dpram_wr_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .flush    (flush),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .rdy      (rdy),
    .len0     (len0),
    .len1     (len1),
    .rel      (rel)
`ifdef DPWR_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic chk_wr(input string tag,
                        input logic [5:0] a,
                        input logic [7:0] d);
    chk({tag, "_we"}, {31'd0, we}, 32'd1);
    chk({tag, "_wa"}, {26'd0, wa}, {26'd0, a});
    chk({tag, "_wd"}, {24'd0, wd}, {24'd0, d});
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    flush    = 1'b0;
    rel      = 2'b00;
    #1;
    chk("rst_we",   {31'd0, we},   32'd0);
    chk("rst_wa",   {26'd0, wa},   32'd0);
    chk("rst_wd",   {24'd0, wd},   32'd0);
    chk("rst_rdy",  {30'd0, rdy},  32'd0);
    chk("rst_len0", {26'd0, len0}, 32'd0);
    chk("rst_len1", {26'd0, len1}, 32'd0);
    chk("rst_irdy", {31'd0, in_ready}, 32'd1);
    step();
    rst = 1'b0;
    step();

    // 32 bytes back-to-back fill half 0
    for (int i = 0; i < 32; i++) begin
      in_valid = 1'b1;
      in_data  = i[7:0];
      step();
      chk_wr("fill0", i[5:0], i[7:0]);
    end
    in_valid = 1'b0;
    chk("fill0_rdy",  {30'd0, rdy},  32'd1);
    chk("fill0_len0", {26'd0, len0}, 32'd32);
    chk("fill0_irdy", {31'd0, in_ready}, 32'd1);
    send(8'h55);
    chk_wr("h1_first", 6'd32, 8'h55);
    step();
    chk("idle_we", {31'd0, we}, 32'd0);
    chk("hold_wa", {26'd0, wa}, 32'd32);
    chk("hold_wd", {24'd0, wd}, 32'h55);

    // free half 0, flush 1-byte half 1
    rel = 2'b01;
    step();
    rel = 2'b00;
    chk("rel0_rdy", {30'd0, rdy}, 32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl1_rdy",  {30'd0, rdy},  32'd2);
    chk("fl1_len1", {26'd0, len1}, 32'd1);
    rel = 2'b10;
    step();
    rel = 2'b00;

    // 5 bytes then flush, then an empty flush
    for (int i = 0; i < 5; i++) begin
      send(8'hA0 + i[7:0]);
      chk_wr("part", i[5:0], 8'hA0 + i[7:0]);
    end
    flush = 1'b1;
    step();
    chk("part_rdy",  {30'd0, rdy},  32'd1);
    chk("part_len0", {26'd0, len0}, 32'd5);
    step();
    flush = 1'b0;
    chk("eflush_rdy",  {30'd0, rdy},  32'd1);
    chk("eflush_len1", {26'd0, len1}, 32'd1);
    chk("eflush_we",   {31'd0, we},   32'd0);
    send(8'hB0);
    chk_wr("b0", 6'd32, 8'hB0);

    // fill rest of half 1; both halves closed
    for (int i = 1; i < 32; i++) begin
      send(8'hC0 + i[7:0]);
      chk_wr("fill1", 6'd32 + i[5:0], 8'hC0 + i[7:0]);
    end
    chk("both_rdy",  {30'd0, rdy},  32'd3);
    chk("both_len1", {26'd0, len1}, 32'd32);
    chk("both_irdy", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b1;
    in_data  = 8'hEE;
    step();
    chk("held_we",   {31'd0, we}, 32'd0);
    chk("held_irdy", {31'd0, in_ready}, 32'd0);
    rel = 2'b01;
    step();
    rel = 2'b00;
    chk("relw_we",   {31'd0, we}, 32'd0);
    chk("relw_rdy",  {30'd0, rdy}, 32'd2);
    chk("relw_irdy", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk_wr("ee", 6'd0, 8'hEE);

    // flush together with byte 31
    for (int i = 1; i < 31; i++) begin
      send(i[7:0]);
      chk_wr("p31", i[5:0], i[7:0]);
    end
    flush = 1'b1;
    send(8'h3F);
    flush = 1'b0;
    chk_wr("f31", 6'd31, 8'h3F);
    chk("f31_rdy",  {30'd0, rdy},  32'd3);
    chk("f31_len0", {26'd0, len0}, 32'd32);
    rel = 2'b11;
    step();
    rel = 2'b00;
    chk("rel11_rdy", {30'd0, rdy}, 32'd0);
    send(8'h40);
    chk_wr("f31_nxt", 6'd32, 8'h40);
    step();
    chk("f31_rdy2", {30'd0, rdy}, 32'd0);

    // flush together with byte at ptr 3
    send(8'h41);
    send(8'h42);
    chk_wr("f3_b2", 6'd34, 8'h42);
    flush = 1'b1;
    send(8'h43);
    flush = 1'b0;
    chk_wr("f3", 6'd35, 8'h43);
    chk("f3_rdy",  {30'd0, rdy},  32'd2);
    chk("f3_len1", {26'd0, len1}, 32'd4);
    rel = 2'b10;
    step();
    rel = 2'b00;

    // rel[0] on the close of half 0: set wins
    send(8'h60);
    send(8'h61);
    flush = 1'b1;
    rel   = 2'b01;
    send(8'h62);
    flush = 1'b0;
    rel   = 2'b00;
    chk_wr("rc", 6'd2, 8'h62);
    chk("rc_rdy",  {30'd0, rdy},  32'd1);
    chk("rc_len0", {26'd0, len0}, 32'd3);
    rel = 2'b10;
    step();
    chk("rel_idle_rdy", {30'd0, rdy}, 32'd1);
    rel = 2'b01;
    step();
    rel = 2'b00;
    chk("rel0b_rdy", {30'd0, rdy}, 32'd0);

    // async reset mid-half with a write pending
    for (int i = 0; i < 10; i++) send(8'h80 + i[7:0]);
    chk_wr("mid", 6'd41, 8'h89);
    in_valid = 1'b1;
    in_data  = 8'h77;
    step();
    in_valid = 1'b0;
    chk("pend_we", {31'd0, we}, 32'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_we",  {31'd0, we},  32'd0);
    chk("arst_wa",  {26'd0, wa},  32'd0);
    chk("arst_wd",  {24'd0, wd},  32'd0);
    chk("arst_rdy", {30'd0, rdy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    send(8'h99);
    chk_wr("post_rst", 6'd0, 8'h99);

`ifdef DPWR_DROP_CNT_EN
    for (int i = 1; i < 64; i++) send(i[7:0]);
    chk("dr_rdy", {30'd0, rdy}, 32'd3);
    chk("dr_cnt0", {24'd0, drop_cnt}, 32'd0);
    begin
      int wes;
      wes = 0;
      in_valid = 1'b1;
      for (int i = 0; i < 300; i++) begin
        in_data = i[7:0];
        step();
        if (we) wes++;
      end
      in_valid = 1'b0;
      chk("dr_we", wes, 32'd0);
    end
    chk("dr_cnt", {24'd0, drop_cnt}, 32'd255);
    chk("dr_irdy", {31'd0, in_ready}, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
